microprocessor_8bit: RTL and testbench

//  8-bit multicycle CPU core of the microcomputer; talks to a 256x8 companion RAM over ram_addr/ram_data/ram_we/ram_out.

---
 rtl/microprocessor_8bit.sv | 112 +++++++++++
 tb/tb_microprocessor_8bit.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/microprocessor_8bit.sv
// microprocessor_8bit: 8-bit multicycle CPU core with fetch/decode/execute FSM and test ports
module microprocessor_8bit (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] ram_out,
  output logic [7:0] ram_addr,
  output logic [7:0] ram_data,
  output logic       ram_we,
  output logic [7:0] test_state,
  output logic [7:0] test_A,
  output logic [7:0] test_B,
  output logic [7:0] test_C,
  output logic [7:0] test_D,
  output logic [7:0] test_Acc,
  output logic [7:0] pc_out,
  output logic [7:0] ir_out
);
  typedef enum logic [1:0] {S0 = 2'd0, S1 = 2'd1, S2 = 2'd2, S3 = 2'd3} state_t;
  state_t     state_q, state_d;
  logic [7:0] regs_q [4];
  logic [7:0] regs_d [4];
  logic [7:0] acc_q, acc_d, pc_q, pc_d, ir_q, ir_d, opr_q, opr_d;
  logic [3:0] op;
  logic [1:0] rd, rs;
  logic [7:0] src;
  logic       two_byte, mem_op;
  assign op       = ir_q[7:4];
  assign rd       = ir_q[3:2];
  assign rs       = ir_q[1:0];
  assign src      = regs_q[rs];
  assign two_byte = op == 4'h2 || op == 4'h3 || op == 4'h4 || op == 4'hD || op == 4'hE;
  assign mem_op   = op == 4'h3 || op == 4'h4;
  // LD/ST address the operand byte in their final cycle; otherwise the bus follows PC
  assign ram_addr   = (state_q == S2 && mem_op) ? opr_q : pc_q;
  assign ram_we     = state_q == S2 && op == 4'h4 && !reset;
  assign ram_data   = src;
  assign test_state = {6'd0, state_q};
  assign test_A     = regs_q[0];
  assign test_B     = regs_q[1];
  assign test_C     = regs_q[2];
  assign test_D     = regs_q[3];
  assign test_Acc   = acc_q;
  assign pc_out     = pc_q;
  assign ir_out     = ir_q;
  // next-state and datapath updates for fetch, decode/execute, second-byte execute and halt
  always_comb begin
    state_d = state_q;
    regs_d  = regs_q;
    acc_d   = acc_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    opr_d   = opr_q;
    case (state_q)
      S0: begin
        ir_d    = ram_out;
        pc_d    = pc_q + 8'd1;
        state_d = S1;
      end
      S1: begin
        if (two_byte) begin
          opr_d   = ram_out;
          pc_d    = pc_q + 8'd1;
          state_d = S2;
        end else begin
          state_d = op == 4'hF ? S3 : S0;
          case (op)
            4'h1: regs_d[rd] = src;
            4'h5: acc_d = acc_q + src;
            4'h6: acc_d = acc_q - src;
            4'h7: acc_d = acc_q & src;
            4'h8: acc_d = acc_q | src;
            4'h9: acc_d = acc_q ^ src;
            4'hA: acc_d = ~acc_q;
            4'hB: acc_d = src;
            4'hC: regs_d[rd] = acc_q;
            default: ;
          endcase
        end
      end
      S2: begin
        state_d = S0;
        case (op)
          4'h2: regs_d[rd] = opr_q;
          4'h3: regs_d[rd] = ram_out;
          4'hD: pc_d = opr_q;
          4'hE: pc_d = acc_q == 8'd0 ? opr_q : pc_q;
          default: ;
        endcase
      end
      S3: state_d = S3;
      default: state_d = S0;
    endcase
  end
  // state register with asynchronous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S0;
      regs_q  <= '{default: 8'h00};
      acc_q   <= 8'h00;
      pc_q    <= 8'h00;
      ir_q    <= 8'h00;
      opr_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      regs_q  <= regs_d;
      acc_q   <= acc_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      opr_q   <= opr_d;
    end
  end
endmodule

// File: tb/tb_microprocessor_8bit.sv
// tb_microprocessor_8bit: directed programs against microprocessor_8bit with a companion RAM
module tb_microprocessor_8bit;
  logic       clk, reset;
  logic [7:0] ram_out, ram_addr, ram_data;
  logic       ram_we;
  logic [7:0] test_state, test_A, test_B, test_C, test_D, test_Acc, pc_out, ir_out;
  logic [7:0] mem [256];
  int checks = 0;
  int failures = 0;

  microprocessor_8bit dut (
    .clk(clk), .reset(reset), .ram_out(ram_out), .ram_addr(ram_addr),
    .ram_data(ram_data), .ram_we(ram_we), .test_state(test_state),
    .test_A(test_A), .test_B(test_B), .test_C(test_C), .test_D(test_D),
    .test_Acc(test_Acc), .pc_out(pc_out), .ir_out(ir_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // companion RAM: combinational read, clocked write
  assign ram_out = mem[ram_addr];
  always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_data;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
  endtask

  task automatic put(input logic [7:0] a, input logic [7:0] d);
    mem[a] <= d;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  int we_cnt;
  logic [7:0] we_addr, we_data;

  initial begin
    reset = 1'b1;
    clear_mem();
    #1;
    check("rst_state", test_state, 8'h00);
    check("rst_pc", pc_out, 8'h00);
    check("rst_acc", test_Acc, 8'h00);
    check("rst_we", {7'd0, ram_we}, 8'h00);
    release_reset();
    check("nop_s0", test_state, 8'h00);
    cycles(1);
    check("nop_s1", test_state, 8'h01);
    check("nop_pc1", pc_out, 8'h01);
    cycles(1);
    check("nop_s0b", test_state, 8'h00);
    check("nop_pc1b", pc_out, 8'h01);
    cycles(4);
    check("nop_pc3", pc_out, 8'h03);
    check("nop_a", test_A, 8'h00);

    reset = 1'b1;
    clear_mem();
    put(0, 8'h20); put(1, 8'h05); put(2, 8'h24); put(3, 8'h03);
    put(4, 8'hB0); put(5, 8'h51); put(6, 8'hF0);
    release_reset();
    cycles(20);
    check("add_acc", test_Acc, 8'h08);
    check("add_a", test_A, 8'h05);
    check("add_b", test_B, 8'h03);
    check("add_state", test_state, 8'h03);
    check("add_pc", pc_out, 8'h07);

    reset = 1'b1;
    clear_mem();
    put(0, 8'h20); put(1, 8'hAA); put(2, 8'h40); put(3, 8'h80);
    put(4, 8'h38); put(5, 8'h80); put(6, 8'h1C); put(7, 8'hF0);
    release_reset();
    we_cnt = 0; we_addr = 8'h00; we_data = 8'h00;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ram_we) begin
        we_cnt++;
        we_addr = ram_addr;
        we_data = ram_data;
      end
    end
    check("st_we_cnt", 8'(we_cnt), 8'h01);
    check("st_addr", we_addr, 8'h80);
    check("st_data", we_data, 8'hAA);
    check("st_mem", mem[8'h80], 8'hAA);
    check("ld_c", test_C, 8'hAA);
    check("mov_d", test_D, 8'hAA);

    reset = 1'b1;
    clear_mem();
    put(0, 8'h24); put(1, 8'h01); put(2, 8'hB0); put(3, 8'h61);
    put(4, 8'hA0); put(5, 8'hE0); put(6, 8'h40); put(8'h40, 8'hF0);
    release_reset();
    cycles(7);
    check("sub_acc", test_Acc, 8'hFF);
    cycles(2);
    check("not_acc", test_Acc, 8'h00);
    cycles(3);
    check("jz_pc", pc_out, 8'h40);
    cycles(4);
    check("jz_halt_pc", pc_out, 8'h41);
    check("jz_halt_st", test_state, 8'h03);

    reset = 1'b1;
    clear_mem();
    put(0, 8'h24); put(1, 8'h01); put(2, 8'hB1); put(3, 8'hE0);
    put(4, 8'h40); put(5, 8'hF0);
    release_reset();
    cycles(12);
    check("jz_nt_pc", pc_out, 8'h06);
    check("jz_nt_st", test_state, 8'h03);

    reset = 1'b1;
    clear_mem();
    put(0, 8'hD0); put(1, 8'h10); put(8'h10, 8'hF0);
    release_reset();
    cycles(3);
    check("jmp_pc", pc_out, 8'h10);
    cycles(2);
    check("jmp_halt_pc", pc_out, 8'h11);
    cycles(100);
    check("hold_pc", pc_out, 8'h11);
    check("hold_state", test_state, 8'h03);

    reset = 1'b1;
    clear_mem();
    put(0, 8'hD0); put(1, 8'hFF); put(8'hFF, 8'h20);
    release_reset();
    cycles(6);
    check("wrap_a", test_A, 8'hD0);
    check("wrap_pc", pc_out, 8'h01);
    cycles(4);
    check("wrap_halt", test_state, 8'h03);

    reset = 1'b1;
    clear_mem();
    put(0, 8'h20); put(1, 8'hAA); put(2, 8'h40); put(3, 8'h80);
    release_reset();
    cycles(5);
    check("abort_s2", test_state, 8'h02);
    check("abort_we_pre", {7'd0, ram_we}, 8'h01);
    #1 reset = 1'b1;
    #1;
    check("abort_we", {7'd0, ram_we}, 8'h00);
    check("abort_a", test_A, 8'h00);
    check("abort_pc", pc_out, 8'h00);
    check("abort_state", test_state, 8'h00);
    @(negedge clk);
    check("abort_mem", mem[8'h80], 8'h00);
    reset = 1'b0;
    @(negedge clk);
    check("restart_st", test_state, 8'h01);
    check("restart_pc", pc_out, 8'h01);
    check("restart_ir", ir_out, 8'h20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
